// File: rtl/framebuffer_writer.sv
// framebuffer_writer: turns pixel/span draw requests into paired linear
// framebuffer writes and clears the new back buffer after a vsync swap.
module framebuffer_writer #(
    parameter int         WIDTH       = 640,
    parameter int         HEIGHT      = 480,
    parameter int         ADDR_W      = 19,
    parameter logic [3:0] CLEAR_COLOR = 4'h0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vsync,
    input  logic              clear_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [9:0]        in_x,
    input  logic [8:0]        in_y,
    input  logic [9:0]        in_len,
    input  logic [3:0]        in_color,
    output logic [ADDR_W-1:0] addr_wr1,
    output logic [ADDR_W-1:0] addr_wr2,
    output logic [3:0]        data_wr1,
    output logic [3:0]        data_wr2,
    output logic              wr1_en,
    output logic              wr2_en,
    output logic              busy,
    output logic              clear_done,
    output logic              overrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SPAN  = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam logic [ADDR_W-1:0] NPAIRS  = ADDR_W'(WIDTH * HEIGHT / 2);
    localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [9:0]        WIDTH_X = 10'(WIDTH);
    localparam logic [9:0]        HEIGHT_Y = 10'(HEIGHT);

    logic [1:0]        state_q, state_d;
    logic [9:0]        x_q, x_d, len_q, len_d, lc_q, lc_d, k_q, k_d;
    logic [8:0]        y_q, y_d;
    logic [3:0]        color_q, color_d;
    logic [ADDR_W-1:0] base_q, base_d, clr_idx_q, clr_idx_d;
    logic              pending_q, pending_d, vsync_q;
    logic              ready_q, ready_d, busy_q, busy_d;
    logic              done_q, done_d, overrun_q, overrun_d;
    logic              wr1_en_q, wr1_en_d, wr2_en_q, wr2_en_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic [3:0]        data1_q, data1_d, data2_q, data2_d;

    logic              vsync_fall_s, range_ok_s;
    logic [9:0]        room_s, lc_s;
    logic [ADDR_W-1:0] y_ext_s, base_s, clr_addr_s;

    assign vsync_fall_s = vsync_q & ~vsync;
    assign y_ext_s      = ADDR_W'(y_q);
    // y*640 reduces to two shifts; other widths fall back to a constant multiply
    assign base_s       = (WIDTH == 640) ? ((y_ext_s << 9) + (y_ext_s << 7) + ADDR_W'(x_q))
                                         : (y_ext_s * WIDTH_A + ADDR_W'(x_q));
    assign room_s       = WIDTH_X - x_q;
    assign range_ok_s   = ({1'b0, y_q} < HEIGHT_Y) && (x_q < WIDTH_X) && (len_q != 10'd0);
    assign lc_s         = range_ok_s ? ((len_q < room_s) ? len_q : room_s) : 10'd0;
    assign clr_addr_s   = clr_idx_q << 1;

    // Next-state, next-output and vsync/clear bookkeeping
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        len_d     = len_q;
        color_d   = color_q;
        base_d    = base_q;
        lc_d      = lc_q;
        k_d       = k_q;
        clr_idx_d = clr_idx_q;
        pending_d = pending_q;
        overrun_d = 1'b0;
        done_d    = 1'b0;
        wr1_en_d  = 1'b0;
        wr2_en_d  = 1'b0;
        addr1_d   = '0;
        addr2_d   = '0;
        data1_d   = 4'h0;
        data2_d   = 4'h0;

        if (vsync_fall_s) begin
            if (state_q == ST_CLEAR) begin
                overrun_d = 1'b1;
            end else if (clear_en) begin
                pending_d = 1'b1;
            end else begin
                pending_d = pending_q;
            end
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid && ready_q) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    len_d   = in_len;
                    color_d = in_color;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                lc_d   = lc_s;
                base_d = base_s;
                if (range_ok_s) begin
                    state_d  = ST_SPAN;
                    wr1_en_d = 1'b1;
                    addr1_d  = base_s;
                    data1_d  = color_q;
                    wr2_en_d = (lc_s > 10'd1);
                    addr2_d  = base_s + ONE_A;
                    data2_d  = color_q;
                    k_d      = 10'd2;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SPAN: begin
                if (k_q < lc_q) begin
                    wr1_en_d = 1'b1;
                    addr1_d  = base_q + ADDR_W'(k_q);
                    data1_d  = color_q;
                    wr2_en_d = ((k_q + 10'd1) < lc_q);
                    addr2_d  = base_q + ADDR_W'(k_q) + ONE_A;
                    data2_d  = color_q;
                    k_d      = k_q + 10'd2;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_idx_q != NPAIRS) begin
                    wr1_en_d  = 1'b1;
                    wr2_en_d  = 1'b1;
                    addr1_d   = clr_addr_s;
                    addr2_d   = clr_addr_s | ONE_A;
                    data1_d   = CLEAR_COLOR;
                    data2_d   = CLEAR_COLOR;
                    clr_idx_d = clr_idx_q + ONE_A;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Whenever the engine would land in IDLE with a clear waiting, start it
        // right away so the first pair follows the last span write directly.
        if ((state_d == ST_IDLE) && pending_q) begin
            state_d   = ST_CLEAR;
            pending_d = 1'b0;
            wr1_en_d  = 1'b1;
            wr2_en_d  = 1'b1;
            addr1_d   = '0;
            addr2_d   = ONE_A;
            data1_d   = CLEAR_COLOR;
            data2_d   = CLEAR_COLOR;
            clr_idx_d = ONE_A;
        end else begin
            clr_idx_d = clr_idx_d;
        end

        ready_d = (state_d == ST_IDLE) && !pending_d;
        busy_d  = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            x_q       <= 10'd0;
            y_q       <= 9'd0;
            len_q     <= 10'd0;
            color_q   <= 4'h0;
            base_q    <= '0;
            lc_q      <= 10'd0;
            k_q       <= 10'd0;
            clr_idx_q <= '0;
            pending_q <= 1'b0;
            vsync_q   <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            wr1_en_q  <= 1'b0;
            wr2_en_q  <= 1'b0;
            addr1_q   <= '0;
            addr2_q   <= '0;
            data1_q   <= 4'h0;
            data2_q   <= 4'h0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            len_q     <= len_d;
            color_q   <= color_d;
            base_q    <= base_d;
            lc_q      <= lc_d;
            k_q       <= k_d;
            clr_idx_q <= clr_idx_d;
            pending_q <= pending_d;
            vsync_q   <= vsync;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            wr1_en_q  <= wr1_en_d;
            wr2_en_q  <= wr2_en_d;
            addr1_q   <= addr1_d;
            addr2_q   <= addr2_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
        end
    end

    assign in_ready   = ready_q;
    assign busy       = busy_q;
    assign clear_done = done_q;
    assign overrun    = overrun_q;
    assign wr1_en     = wr1_en_q;
    assign wr2_en     = wr2_en_q;
    assign addr_wr1   = addr1_q;
    assign addr_wr2   = addr2_q;
    assign data_wr1   = data1_q;
    assign data_wr2   = data2_q;

endmodule
